temporizador_regressivo: RTL and testbench
==========================================

Name: temporizador_regressivo

Overview:
BCD countdown timer (MM:SS, max 59:59) built for the same board as the real-time clock: same 1 Hz time base, same BCD digit encoding, counting in the opposite direction. Operator loads a start time, starts/pauses the countdown, and gets a done flag at 00:00. Digit outputs feed the team's bcd-to-7-segment decoders directly; msd digits are 3 bits wide and are zero-extended at the decoder.

Parameters:
DIV, 50000000, clock cycles per 1 s tick (prescaler terminal count + 1); minimum 2.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  load set_* digits into the counter (level, sampled each cycle)
set_m_msd  in  3  minutes tens digit to load, BCD 0-5
set_m_lsd  in  4  minutes units digit to load, BCD 0-9
set_s_msd  in  3  seconds tens digit to load, BCD 0-5
set_s_lsd  in  4  seconds units digit to load, BCD 0-9
start  in  1  begin/resume countdown
pause  in  1  suspend countdown
m_msd  out  3  current minutes tens, BCD
m_lsd  out  4  current minutes units, BCD
s_msd  out  3  current seconds tens, BCD
s_lsd  out  4  current seconds units, BCD
running  out  1  high while in RUN
done  out  1  high while in DONE

Behaviour:
- Reset: all digits 0, state IDLE, prescaler 0, running=0, done=0. Takes priority over every other input.
- States: IDLE, RUN, PAUSED, DONE. All outputs registered, updated on the rising clock edge.
- load: accepted in IDLE, PAUSED, DONE; ignored in RUN. Next state is IDLE, prescaler cleared, done cleared. Out-of-range digits saturate: lsd>9 -> 9, msd>5 -> 5. load has priority over start and pause in the same cycle.
- start: IDLE or PAUSED with value != 00:00 -> RUN. start with value 00:00 is ignored (stays in IDLE). start in DONE is ignored.
- pause: RUN -> PAUSED. Prescaler and digits are held. If start and pause are asserted together in RUN, pause wins. pause outside RUN is ignored.
- Prescaler: counts 0..DIV-1 only in RUN. tick = (count == DIV-1), then wraps to 0. Entering RUN from IDLE starts the count at 0, so the first decrement happens DIV cycles after the start edge. Resuming from PAUSED continues from the held count.
- Decrement on tick, BCD with borrow:
  - s_lsd 0 -> 9 with borrow, else s_lsd-1
  - s_msd under borrow: 0 -> 5 with borrow, else -1
  - m_lsd under borrow: 0 -> 9 with borrow, else -1
  - m_msd under borrow: -1
- Terminal: on the tick that produces 00:00, the digits become 00:00 and the state becomes DONE on the same edge. running=0 and done=1 from that edge. No underflow past 00:00 ever.
- DONE holds 00:00 and done=1 until load or reset.
- running = (state==RUN). done = (state==DONE). They are never both 1.
- Reset mid-run: the next edge gives the reset values regardless of state.

Test Plan:
- DIV=4; reset, load 00:03, start -> s_lsd is 2 at start+4 cycles, 1 at +8, 0 at +12; done=1 and running=0 at +12.
- DIV=4; load 10:00, start -> after one tick the display reads 09:59 (m_msd=0, m_lsd=9, s_msd=5, s_lsd=9).
- DIV=4; load 00:05, start, pause 2 cycles after start, hold 10 cycles, start -> still 00:05 while paused; 00:04 appears 2 cycles after resume.
- load with set_s_lsd=12, set_s_msd=7 -> outputs 00:59. start with 00:00 loaded -> stays IDLE, running=0, done=0.
- RUN at 01:00, assert load (00:30) -> ignored, countdown continues. Start+pause in the same cycle -> PAUSED.
- DONE state: start -> no change, done stays 1. load 00:02 -> IDLE, done=0. Reset asserted mid-RUN -> 00:00, running=0 on the next edge.

Source files
------------

// File: rtl/temporizador_regressivo.sv
// BCD countdown timer, MM:SS up to 59:59, decremented once per DIV-cycle tick.
// Load/start/pause control through a four-state FSM; all outputs registered.
module temporizador_regressivo #(
  parameter int unsigned DIV = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] set_m_msd,
  input  logic [3:0] set_m_lsd,
  input  logic [2:0] set_s_msd,
  input  logic [3:0] set_s_lsd,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] m_msd,
  output logic [3:0] m_lsd,
  output logic [2:0] s_msd,
  output logic [3:0] s_lsd,
  output logic       running,
  output logic       done
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] presc_q, presc_d;
  logic [2:0]      m_msd_q, m_msd_d;
  logic [3:0]      m_lsd_q, m_lsd_d;
  logic [2:0]      s_msd_q, s_msd_d;
  logic [3:0]      s_lsd_q, s_lsd_d;
  logic            running_q, done_q;

  // Decremented value and borrow chain
  logic [2:0] m_msd_dec;
  logic [3:0] m_lsd_dec;
  logic [2:0] s_msd_dec;
  logic [3:0] s_lsd_dec;
  logic       borrow_s, borrow_sm, borrow_ml;
  logic       dec_zero, cur_zero, tick;

  // BCD decrement with borrow, plus zero detection on current and next value
  always_comb begin
    borrow_s  = (s_lsd_q == 4'd0);
    borrow_sm = borrow_s && (s_msd_q == 3'd0);
    borrow_ml = borrow_sm && (m_lsd_q == 4'd0);

    s_lsd_dec = borrow_s ? 4'd9 : s_lsd_q - 4'd1;
    s_msd_dec = s_msd_q;
    if (borrow_s) s_msd_dec = (s_msd_q == 3'd0) ? 3'd5 : s_msd_q - 3'd1;
    m_lsd_dec = m_lsd_q;
    if (borrow_sm) m_lsd_dec = (m_lsd_q == 4'd0) ? 4'd9 : m_lsd_q - 4'd1;
    m_msd_dec = borrow_ml ? m_msd_q - 3'd1 : m_msd_q;

    dec_zero = (m_msd_dec == 3'd0) && (m_lsd_dec == 4'd0) &&
               (s_msd_dec == 3'd0) && (s_lsd_dec == 4'd0);
    cur_zero = (m_msd_q == 3'd0) && (m_lsd_q == 4'd0) &&
               (s_msd_q == 3'd0) && (s_lsd_q == 4'd0);
    tick     = (presc_q == CntMax);
  end

  // Next-state logic: load > pause > start; decrement only on tick in RUN
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    m_msd_d = m_msd_q;
    m_lsd_d = m_lsd_q;
    s_msd_d = s_msd_q;
    s_lsd_d = s_lsd_q;

    if (state_q != StRun && load) begin
      state_d = StIdle;
      presc_d = '0;
      m_msd_d = (set_m_msd > 3'd5) ? 3'd5 : set_m_msd;
      m_lsd_d = (set_m_lsd > 4'd9) ? 4'd9 : set_m_lsd;
      s_msd_d = (set_s_msd > 3'd5) ? 3'd5 : set_s_msd;
      s_lsd_d = (set_s_lsd > 4'd9) ? 4'd9 : set_s_lsd;
    end else begin
      unique case (state_q)
        StIdle, StPaused: begin
          // IDLE always holds a cleared prescaler, so PAUSED resumes mid-count
          if (start && !cur_zero) state_d = StRun;
        end
        StRun: begin
          if (pause) begin
            state_d = StPaused;
          end else if (tick) begin
            presc_d = '0;
            m_msd_d = m_msd_dec;
            m_lsd_d = m_lsd_dec;
            s_msd_d = s_msd_dec;
            s_lsd_d = s_lsd_dec;
            if (dec_zero) state_d = StDone;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset; status flags follow next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      m_msd_q   <= '0;
      m_lsd_q   <= '0;
      s_msd_q   <= '0;
      s_lsd_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      m_msd_q   <= m_msd_d;
      m_lsd_q   <= m_lsd_d;
      s_msd_q   <= s_msd_d;
      s_lsd_q   <= s_lsd_d;
      running_q <= (state_d == StRun);
      done_q    <= (state_d == StDone);
    end
  end

  assign m_msd   = m_msd_q;
  assign m_lsd   = m_lsd_q;
  assign s_msd   = s_msd_q;
  assign s_lsd   = s_lsd_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Directed bench for temporizador_regressivo with DIV=4.
module tb_temporizador_regressivo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [2:0] set_m_msd = '0;
  logic [3:0] set_m_lsd = '0;
  logic [2:0] set_s_msd = '0;
  logic [3:0] set_s_lsd = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] m_msd;
  logic [3:0] m_lsd;
  logic [2:0] s_msd;
  logic [3:0] s_lsd;
  logic       running;
  logic       done;

  int checks = 0;
  int failures = 0;

  temporizador_regressivo #(.DIV(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .set_m_msd (set_m_msd),
    .set_m_lsd (set_m_lsd),
    .set_s_msd (set_s_msd),
    .set_s_lsd (set_s_lsd),
    .start     (start),
    .pause     (pause),
    .m_msd     (m_msd),
    .m_lsd     (m_lsd),
    .s_msd     (s_msd),
    .s_lsd     (s_lsd),
    .running   (running),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit later
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_load(input logic [2:0] mm, input logic [3:0] ml,
                         input logic [2:0] sm, input logic [3:0] sl);
    set_m_msd = mm;
    set_m_lsd = ml;
    set_s_msd = sm;
    set_s_lsd = sl;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  function automatic logic [31:0] disp();
    return {18'd0, m_msd, m_lsd, s_msd, s_lsd};
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] mm, input logic [3:0] ml,
                                     input logic [2:0] sm, input logic [3:0] sl);
    return {18'd0, mm, ml, sm, sl};
  endfunction

  function automatic logic [31:0] flags();
    return {30'd0, running, done};
  endfunction

  initial begin
    // Reset state
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check_eq("reset_disp", disp(), mk(0, 0, 0, 0));
    check_eq("reset_flags", flags(), 32'd0);

    // 00:03 countdown, one decrement every 4 cycles
    do_load(0, 0, 0, 3);
    check_eq("load3_disp", disp(), mk(0, 0, 0, 3));
    pulse_start();
    check_eq("run_flags", flags(), 32'd2);
    step(3);
    check_eq("pre_tick", s_lsd, 32'd3);
    step(1);
    check_eq("s_lsd_2", s_lsd, 32'd2);
    step(4);
    check_eq("s_lsd_1", s_lsd, 32'd1);
    step(4);
    check_eq("s_lsd_0", disp(), mk(0, 0, 0, 0));
    check_eq("done_flags", flags(), 32'd1);
    step(3);
    check_eq("done_hold", disp(), mk(0, 0, 0, 0));

    // 10:00 -> 09:59 borrow across all digits
    do_load(1, 0, 0, 0);
    check_eq("load_from_done", flags(), 32'd0);
    pulse_start();
    step(4);
    check_eq("borrow_0959", disp(), mk(0, 9, 5, 9));

    // Pause holds digits and prescaler
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    do_load(0, 0, 0, 5);
    pulse_start();
    step(2);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    check_eq("paused_flags", flags(), 32'd0);
    step(10);
    check_eq("paused_hold", disp(), mk(0, 0, 0, 5));
    pulse_start();
    check_eq("resume_flags", flags(), 32'd2);
    step(1);
    check_eq("resume_plus1", disp(), mk(0, 0, 0, 5));
    step(1);
    check_eq("resume_plus2", disp(), mk(0, 0, 0, 4));

    // Saturating load from PAUSED, then start with zero value
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    do_load(0, 0, 7, 12);
    check_eq("saturate", disp(), mk(0, 0, 5, 9));
    do_load(0, 0, 0, 0);
    pulse_start();
    check_eq("zero_start_flags", flags(), 32'd0);
    step(4);
    check_eq("zero_start_disp", disp(), mk(0, 0, 0, 0));

    // load ignored in RUN
    do_load(0, 1, 0, 0);
    pulse_start();
    do_load(0, 0, 3, 0);
    check_eq("load_in_run", disp(), mk(0, 1, 0, 0));
    check_eq("load_in_run_fl", flags(), 32'd2);
    step(3);
    check_eq("run_0059", disp(), mk(0, 0, 5, 9));

    // start+pause together in RUN -> PAUSED
    start = 1'b1;
    pause = 1'b1;
    step(1);
    start = 1'b0;
    pause = 1'b0;
    check_eq("start_pause", flags(), 32'd0);
    step(8);
    check_eq("start_pause_hold", disp(), mk(0, 0, 5, 9));

    // DONE ignores start; load leaves DONE
    do_load(0, 0, 0, 1);
    pulse_start();
    step(4);
    check_eq("done2_flags", flags(), 32'd1);
    pulse_start();
    check_eq("done_start_ign", flags(), 32'd1);
    do_load(0, 0, 0, 2);
    check_eq("done_load_fl", flags(), 32'd0);
    check_eq("done_load_disp", disp(), mk(0, 0, 0, 2));

    // Reset mid-run
    pulse_start();
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("midrun_rst_disp", disp(), mk(0, 0, 0, 0));
    check_eq("midrun_rst_fl", flags(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
